s27_key_loader: RTL and testbench

Key-provisioning controller that drives the key and random-source inputs of the locked s27 core (`s1`, `s2`, `random`). It receives a serial key frame over a valid/ready bit handshake, checks its parity, and presents the accepted key on parallel outputs. It counts bad frames and enters a sticky lockout after too many. A free-running LFSR supplies the core's `random` input. It sits between the test/provisioning port and the locked netlist.

---
 rtl/s27_key_loader_if.sv | 43 ++++
 rtl/s27_key_loader.sv | 162 ++++++++++++++++
 tb/tb_s27_key_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/s27_key_loader_if.sv
// Bit-serial key provisioning bus between the test/provisioning port and s27_key_loader.
// Latency: none (wires only); all loader-side outputs are registered inside the loader.
// Backpressure: SR gates bit acceptance; SV while SR=0 is dropped, not stalled.
interface s27_key_loader_if #(
    parameter int KEY_W = 2
);
    // Provisioning side -> loader
    logic             SI;       // serial key/parity bit
    logic             SV;       // SI valid
    logic             ABORT;    // discard partial frame

    // Loader -> provisioning side / locked core
    logic             SR;       // ready to accept a bit
    logic [KEY_W-1:0] KEY;      // applied key (bit 0 -> s1, bit 1 -> s2)
    logic             KEY_VLD;  // KEY holds an accepted frame
    logic             ERR;      // one-cycle bad-frame pulse
    logic             LOCKOUT;  // sticky lockout flag
    logic             RANDOM;   // random bit for the core

    modport master (
        output SI,
        output SV,
        output ABORT,
        input  SR,
        input  KEY,
        input  KEY_VLD,
        input  ERR,
        input  LOCKOUT,
        input  RANDOM
    );

    modport slave (
        input  SI,
        input  SV,
        input  ABORT,
        output SR,
        output KEY,
        output KEY_VLD,
        output ERR,
        output LOCKOUT,
        output RANDOM
    );
endinterface

// File: rtl/s27_key_loader.sv
// Key loader for the locked s27 core: serial parity-checked key frames -> parallel KEY, lockout, LFSR random bit.
// Latency: KEY/KEY_VLD/ERR/LOCKOUT update on the edge accepting the parity bit; frame takes KEY_W+1 cycles minimum.
// Backpressure: SR=1 in IDLE/SHIFT (one bit per cycle, back-to-back frames allowed); SR=0 forever in LOCKOUT until RN.
// Build option: define S27_KEY_LFSR_EN to compile the 8-bit LFSR that drives RANDOM; otherwise RANDOM is tied to 0.
module s27_key_loader #(
    parameter int          KEY_W     = 2,
    parameter int          MAX_ERR   = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic           CK,
    input  logic           RN,
    s27_key_loader_if.slave bus
);

    // Bit counter covers key bit indices 0..KEY_W-1 plus the parity index KEY_W.
    localparam int CNT_W = (KEY_W + 1 > 1) ? $clog2(KEY_W + 1) : 1;
    // Error counter holds 0..MAX_ERR.
    localparam int ERR_W = (MAX_ERR + 1 > 1) ? $clog2(MAX_ERR + 1) : 1;

    localparam logic [CNT_W-1:0] PARITY_IDX = CNT_W'(KEY_W);
    localparam logic [ERR_W-1:0] ERR_LIMIT  = ERR_W'(MAX_ERR);

    // FSM encoding
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_LOCK  = 2'b10;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [KEY_W-1:0] shift_q,   shift_d;
    logic             par_q,     par_d;      // running XOR of key bits seen so far
    logic [KEY_W-1:0] key_q,     key_d;
    logic             key_vld_q, key_vld_d;
    logic             err_q,     err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] err_cnt_inc;

    // Saturating increment; in practice lockout is entered before the limit could be passed.
    assign err_cnt_inc = (err_cnt_q == ERR_LIMIT) ? err_cnt_q : err_cnt_q + ERR_W'(1);

    // Next-state logic for frame assembly, parity check, error counting and lockout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        key_d     = key_q;
        key_vld_d = key_vld_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            S_IDLE, S_SHIFT: begin
                if (bus.ABORT) begin
                    // Drop the partial frame; the applied key and error history stay untouched.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                    par_d   = 1'b0;
                end else if (bus.SV) begin
                    if (cnt_q == PARITY_IDX) begin
                        // Parity bit: resolve the frame and get ready for the next one.
                        cnt_d   = '0;
                        shift_d = '0;
                        par_d   = 1'b0;
                        state_d = S_IDLE;
                        if ((par_q ^ bus.SI) == 1'b0) begin
                            key_d     = shift_q;
                            key_vld_d = 1'b1;
                            err_cnt_d = '0;
                        end else begin
                            key_d     = '0;
                            key_vld_d = 1'b0;
                            err_d     = 1'b1;
                            err_cnt_d = err_cnt_inc;
                            if (err_cnt_inc == ERR_LIMIT) begin
                                state_d = S_LOCK;
                            end
                        end
                    end else begin
                        // Key bit, LSB first: bit index equals the current count.
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shift_d[i] = bus.SI;
                            end
                        end
                        par_d   = par_q ^ bus.SI;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_SHIFT;
                    end
                end
            end
            S_LOCK: begin
                // Nothing but reset leaves lockout; keep the key blanked.
                key_d     = '0;
                key_vld_d = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                shift_d   = '0;
                par_d     = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            key_q     <= '0;
            key_vld_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            key_q     <= key_d;
            key_vld_q <= key_vld_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Outputs are decodes of registered state only; no input reaches an output combinationally.
    assign bus.SR      = (state_q != S_LOCK);
    assign bus.LOCKOUT = (state_q == S_LOCK);
    assign bus.KEY     = key_q;
    assign bus.KEY_VLD = key_vld_q;
    assign bus.ERR     = err_q;

`ifdef S27_KEY_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1; free-runs even in lockout.
    always_comb begin
        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};
    end

    // LFSR register; the seed must be nonzero or the sequence sticks at 0.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bus.RANDOM = lfsr_q[7];
`else
    // No LFSR in this build; the seed has no role, masking it keeps RANDOM a constant 0.
    assign bus.RANDOM = 1'b0 & LFSR_SEED[0];
`endif

endmodule

// File: tb/tb_s27_key_loader.sv
// Directed self-checking bench for s27_key_loader (frames, abort, lockout, error clearing, RANDOM source).
// Latency: checks sampled on the falling edge after the edge that accepts each parity bit.
// Backpressure: exercises SV while SR=0 in lockout; covers both S27_KEY_LFSR_EN builds.
module tb_s27_key_loader;

    logic CK;
    logic RN;
    int   checks;
    int   errors;

    s27_key_loader_if #(.KEY_W(2)) bus ();

    s27_key_loader #(
        .KEY_W     (2),
        .MAX_ERR   (3),
        .LFSR_SEED (8'hA5)
    ) dut (
        .CK  (CK),
        .RN  (RN),
        .bus (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive n bits (b[0] first) on consecutive cycles, then drop SV.
    task automatic drive_bits(input logic [2:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.SV = 1'b1;
            bus.SI = b[i];
            @(posedge CK); #1;
        end
        bus.SV = 1'b0;
        bus.SI = 1'b0;
    endtask

    // Pulse reset low across one rising edge, release just after a rising edge.
    task automatic do_reset();
        @(negedge CK);
        RN = 1'b0;
        @(posedge CK); #1;
        RN = 1'b1;
    endtask

    task automatic test_reset();
        drive_bits(3'b001, 2);   // leave a partial frame in flight
        @(negedge CK);
        RN = 1'b0;
        #1;
        checks++; if (bus.SR !== 1'b1) begin errors++; $display("FAIL reset_sr got %b want 1", bus.SR); end
        checks++; if (bus.KEY !== 2'b00) begin errors++; $display("FAIL reset_key got %b want 00", bus.KEY); end
        checks++; if (bus.KEY_VLD !== 1'b0) begin errors++; $display("FAIL reset_key_vld got %b want 0", bus.KEY_VLD); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.ERR); end
        checks++; if (bus.LOCKOUT !== 1'b0) begin errors++; $display("FAIL reset_lockout got %b want 0", bus.LOCKOUT); end
`ifdef S27_KEY_LFSR_EN
        checks++; if (bus.RANDOM !== 1'b1) begin errors++; $display("FAIL reset_random got %b want 1", bus.RANDOM); end
`else
        checks++; if (bus.RANDOM !== 1'b0) begin errors++; $display("FAIL reset_random got %b want 0", bus.RANDOM); end
`endif
        @(posedge CK); #1;
        RN = 1'b1;
    endtask

    task automatic test_good_frame();
        do_reset();
        bus.SV = 1'b1; bus.SI = 1'b0;
        @(posedge CK); #1;
        checks++; if (bus.KEY_VLD !== 1'b0) begin errors++; $display("FAIL good_mid_vld got %b want 0", bus.KEY_VLD); end
        bus.SI = 1'b1;
        @(posedge CK); #1;
        bus.SI = 1'b1;
        @(posedge CK); #1;
        bus.SV = 1'b0; bus.SI = 1'b0;
        @(negedge CK);
        checks++; if (bus.KEY !== 2'b10) begin errors++; $display("FAIL good_key got %b want 10", bus.KEY); end
        checks++; if (bus.KEY_VLD !== 1'b1) begin errors++; $display("FAIL good_key_vld got %b want 1", bus.KEY_VLD); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL good_err got %b want 0", bus.ERR); end
        checks++; if (bus.SR !== 1'b1) begin errors++; $display("FAIL good_sr got %b want 1", bus.SR); end
    endtask

    task automatic test_lockout();
        do_reset();
        drive_bits(3'b110, 3);           // good frame, KEY=10
        for (int f = 0; f < 3; f++) begin
            drive_bits(3'b001, 3);       // bits 1,0,0: odd ones -> bad
            @(negedge CK);
            checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL lock_err_pulse%0d got %b want 1", f, bus.ERR); end
            checks++; if (bus.KEY_VLD !== 1'b0) begin errors++; $display("FAIL lock_key_vld%0d got %b want 0", f, bus.KEY_VLD); end
            checks++; if (bus.LOCKOUT !== (f == 2)) begin errors++; $display("FAIL lock_flag%0d got %b want %b", f, bus.LOCKOUT, f == 2); end
            @(negedge CK);
            checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL lock_err_end%0d got %b want 0", f, bus.ERR); end
        end
        checks++; if (bus.SR !== 1'b0) begin errors++; $display("FAIL lock_sr got %b want 0", bus.SR); end
        checks++; if (bus.KEY !== 2'b00) begin errors++; $display("FAIL lock_key got %b want 00", bus.KEY); end
        // Good frame and abort while locked must change nothing.
        @(posedge CK); #1;
        drive_bits(3'b110, 3);
        bus.ABORT = 1'b1;
        @(posedge CK); #1;
        bus.ABORT = 1'b0;
        drive_bits(3'b110, 3);
        @(negedge CK);
        checks++; if (bus.KEY !== 2'b00) begin errors++; $display("FAIL lock_hold_key got %b want 00", bus.KEY); end
        checks++; if (bus.KEY_VLD !== 1'b0) begin errors++; $display("FAIL lock_hold_vld got %b want 0", bus.KEY_VLD); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL lock_hold_err got %b want 0", bus.ERR); end
        checks++; if (bus.LOCKOUT !== 1'b1) begin errors++; $display("FAIL lock_hold_flag got %b want 1", bus.LOCKOUT); end
        do_reset();
        @(negedge CK);
        checks++; if (bus.LOCKOUT !== 1'b0) begin errors++; $display("FAIL lock_exit_flag got %b want 0", bus.LOCKOUT); end
        checks++; if (bus.SR !== 1'b1) begin errors++; $display("FAIL lock_exit_sr got %b want 1", bus.SR); end
    endtask

    task automatic test_abort();
        do_reset();
        drive_bits(3'b011, 2);           // bits 1,1
        bus.ABORT = 1'b1; bus.SV = 1'b1; bus.SI = 1'b1;
        @(posedge CK); #1;
        bus.ABORT = 1'b0; bus.SV = 1'b0; bus.SI = 1'b0;
        @(negedge CK);
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL abort_err got %b want 0", bus.ERR); end
        checks++; if (bus.KEY_VLD !== 1'b0) begin errors++; $display("FAIL abort_vld got %b want 0", bus.KEY_VLD); end
        @(posedge CK); #1;
        drive_bits(3'b101, 3);           // bits 1,0,1 -> KEY=01
        @(negedge CK);
        checks++; if (bus.KEY !== 2'b01) begin errors++; $display("FAIL abort_next_key got %b want 01", bus.KEY); end
        checks++; if (bus.KEY_VLD !== 1'b1) begin errors++; $display("FAIL abort_next_vld got %b want 1", bus.KEY_VLD); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL abort_next_err got %b want 0", bus.ERR); end
        checks++; if (dut.err_cnt_q !== 2'd0) begin errors++; $display("FAIL abort_errcnt got %0d want 0", dut.err_cnt_q); end
        // Abort alone mid-frame keeps the applied key.
        @(posedge CK); #1;
        drive_bits(3'b001, 1);
        bus.ABORT = 1'b1;
        @(posedge CK); #1;
        bus.ABORT = 1'b0;
        @(negedge CK);
        checks++; if (bus.KEY !== 2'b01) begin errors++; $display("FAIL abort_keep_key got %b want 01", bus.KEY); end
        checks++; if (bus.KEY_VLD !== 1'b1) begin errors++; $display("FAIL abort_keep_vld got %b want 1", bus.KEY_VLD); end
    endtask

    task automatic test_err_clear();
        do_reset();
        drive_bits(3'b001, 3);           // bad
        drive_bits(3'b001, 3);           // bad
        @(negedge CK);
        checks++; if (dut.err_cnt_q !== 2'd2) begin errors++; $display("FAIL clr_cnt_two got %0d want 2", dut.err_cnt_q); end
        @(posedge CK); #1;
        drive_bits(3'b011, 3);           // good: 1,1,0 -> KEY=11
        @(negedge CK);
        checks++; if (dut.err_cnt_q !== 2'd0) begin errors++; $display("FAIL clr_cnt_zero got %0d want 0", dut.err_cnt_q); end
        checks++; if (bus.KEY !== 2'b11) begin errors++; $display("FAIL clr_key got %b want 11", bus.KEY); end
        @(posedge CK); #1;
        drive_bits(3'b001, 3);           // bad
        drive_bits(3'b001, 3);           // bad
        @(negedge CK);
        checks++; if (bus.LOCKOUT !== 1'b0) begin errors++; $display("FAIL clr_lockout got %b want 0", bus.LOCKOUT); end
        checks++; if (bus.SR !== 1'b1) begin errors++; $display("FAIL clr_sr got %b want 1", bus.SR); end
        checks++; if (dut.err_cnt_q !== 2'd2) begin errors++; $display("FAIL clr_cnt_end got %0d want 2", dut.err_cnt_q); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_bits(3'b110, 3);           // 0,1,1 -> KEY=10
        checks++; if (bus.KEY !== 2'b10) begin errors++; $display("FAIL b2b_first_key got %b want 10", bus.KEY); end
        drive_bits(3'b011, 2);           // next frame starts immediately: 1,1
        checks++; if (bus.KEY !== 2'b10) begin errors++; $display("FAIL b2b_hold_key got %b want 10", bus.KEY); end
        checks++; if (bus.KEY_VLD !== 1'b1) begin errors++; $display("FAIL b2b_hold_vld got %b want 1", bus.KEY_VLD); end
        drive_bits(3'b000, 1);           // parity 0
        @(negedge CK);
        checks++; if (bus.KEY !== 2'b11) begin errors++; $display("FAIL b2b_second_key got %b want 11", bus.KEY); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL b2b_err got %b want 0", bus.ERR); end
    endtask

`ifdef S27_KEY_LFSR_EN
    task automatic test_lfsr();
        logic [7:0] m;
        @(negedge CK);
        RN = 1'b0;
        #1;
        checks++; if (bus.RANDOM !== 1'b1) begin errors++; $display("FAIL lfsr_seed_bit got %b want 1", bus.RANDOM); end
        @(posedge CK); #1;
        RN = 1'b1;
        @(posedge CK); #1;
        checks++; if (bus.RANDOM !== 1'b0) begin errors++; $display("FAIL lfsr_step1_bit got %b want 0", bus.RANDOM); end
        checks++; if (dut.lfsr_q !== 8'h4A) begin errors++; $display("FAIL lfsr_step1_state got %h want 4a", dut.lfsr_q); end
        m = 8'h4A;
        for (int i = 1; i < 255; i++) begin
            @(posedge CK); #1;
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
            checks++; if (bus.RANDOM !== m[7]) begin errors++; $display("FAIL lfsr_seq%0d got %b want %b", i, bus.RANDOM, m[7]); end
            checks++; if (dut.lfsr_q === 8'h00) begin errors++; $display("FAIL lfsr_zero%0d got 00 want nonzero", i); end
        end
        checks++; if (dut.lfsr_q !== 8'hA5) begin errors++; $display("FAIL lfsr_period got %h want a5", dut.lfsr_q); end
    endtask
`else
    task automatic test_random_tied();
        do_reset();
        bus.SV = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.SI = (i % 3 != 0);       // frames 0,1,1 twice
            @(negedge CK);
            checks++; if (bus.RANDOM !== 1'b0) begin errors++; $display("FAIL random_tied%0d got %b want 0", i, bus.RANDOM); end
            @(posedge CK); #1;
        end
        bus.SV = 1'b0; bus.SI = 1'b0;
        @(negedge CK);
        checks++; if (bus.KEY !== 2'b10) begin errors++; $display("FAIL random_tied_key got %b want 10", bus.KEY); end
        checks++; if (bus.KEY_VLD !== 1'b1) begin errors++; $display("FAIL random_tied_vld got %b want 1", bus.KEY_VLD); end
        checks++; if (bus.RANDOM !== 1'b0) begin errors++; $display("FAIL random_tied_end got %b want 0", bus.RANDOM); end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        RN        = 1'b0;
        bus.SI    = 1'b0;
        bus.SV    = 1'b0;
        bus.ABORT = 1'b0;
        @(posedge CK); #1;
        RN = 1'b1;

        test_reset();
        test_good_frame();
        test_lockout();
        test_abort();
        test_err_clear();
        test_back_to_back();
`ifdef S27_KEY_LFSR_EN
        test_lfsr();
`else
        test_random_tied();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
